// File: rtl/fifo_mac_reader_if.sv
// Bundle between the sample/coefficient FIFO read port, the MAC reader and the
// downstream summation stage.
interface fifo_mac_reader_if #(
  parameter int AWIDTH = 18,
  parameter int BWIDTH = 25,
  parameter int ACCW   = 48
);
  // FIFO side: rd_en pops one (a, b) pair; a_in/b_in carry it the following cycle.
  logic              empty;
  logic              rd_en;
  logic [AWIDTH-1:0] a_in;
  logic [BWIDTH-1:0] b_in;

  // Result side, strict valid/ready: y is transferred on every rising edge where
  // y_valid && y_ready; while y_valid is high and not accepted, y holds steady and
  // y_valid cannot drop.
  logic [ACCW-1:0]   y;
  logic              y_valid;
  logic              y_ready;
  logic [15:0]       frame_cnt;

  modport master (
    input  empty, a_in, b_in, y_ready,
    output rd_en, y, y_valid, frame_cnt
  );

  modport slave (
    output empty, a_in, b_in, y_ready,
    input  rd_en, y, y_valid, frame_cnt
  );
endinterface

// File: rtl/fifo_mac_reader.sv
// Read-side controller of the FIR operand FIFO: pops (a, b) pairs, multiplies and
// accumulates TAPS of them, and offers each frame's dot-product on valid/ready.
module fifo_mac_reader #(
  parameter int AWIDTH = 18,
  parameter int BWIDTH = 25,
  parameter int TAPS   = 32,
  parameter int ACCW   = 48
) (
  input logic              clk,
  input logic              rst,
  fifo_mac_reader_if.master bus
);
  localparam int          PW       = AWIDTH + BWIDTH;
  localparam logic [15:0] LAST_IDX = 16'(TAPS - 1);

  logic [15:0]            issue_cnt_q, issue_cnt_d;
  logic                   v1_q, last1_q;
  logic                   v2_q, last2_q;
  logic signed [ACCW-1:0] p_q;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [ACCW-1:0] y_q, y_d;
  logic                   y_valid_q, y_valid_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;

  logic                   rd_en;
  logic                   load_result;
  logic signed [PW-1:0]   a_x, b_x, prod;
  logic signed [ACCW-1:0] prod_ext, sum;

  // Pops stall only while a finished result waits; the two pipeline stages keep
  // draining, which is safe because TAPS >= 4 keeps the next last product away.
  assign rd_en = !rst && !bus.empty && !(y_valid_q && !bus.y_ready);

  assign a_x      = PW'($signed(bus.a_in));
  assign b_x      = PW'($signed(bus.b_in));
  assign prod     = a_x * b_x;
  assign prod_ext = ACCW'(prod);
  assign sum      = acc_q + p_q;

  assign issue_cnt_d = (issue_cnt_q == LAST_IDX) ? 16'd0 : issue_cnt_q + 16'd1;
  assign load_result = v2_q && last2_q;

  always_comb begin
    acc_d       = acc_q;
    y_d         = y_q;
    y_valid_d   = y_valid_q;
    frame_cnt_d = frame_cnt_q;
    if (y_valid_q && bus.y_ready) begin
      y_valid_d = 1'b0;
    end
    // A freshly completed frame wins over the handshake clearing y_valid.
    if (v2_q) begin
      if (last2_q) begin
        y_d         = sum;
        acc_d       = '0;
        y_valid_d   = 1'b1;
        frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt_q <= '0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      v2_q        <= 1'b0;
      last2_q     <= 1'b0;
      p_q         <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      y_valid_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      v1_q    <= rd_en;
      last1_q <= rd_en && (issue_cnt_q == LAST_IDX);
      if (rd_en) begin
        issue_cnt_q <= issue_cnt_d;
      end
      v2_q    <= v1_q;
      last2_q <= v1_q && last1_q;
      if (v1_q) begin
        p_q <= prod_ext;
      end
      acc_q       <= acc_d;
      y_q         <= y_d;
      y_valid_q   <= y_valid_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.rd_en     = rd_en;
  assign bus.y         = y_q;
  assign bus.y_valid   = y_valid_q;
  assign bus.frame_cnt = frame_cnt_q;

  logic unused_ok;
  assign unused_ok = load_result;
endmodule

// File: tb/tb_fifo_mac_reader.sv
// Self-checking bench for fifo_mac_reader: a FIFO model feeds pairs, a stream-level
// dot-product model fills the expected queue, and a monitor checks every result.
module tb_fifo_mac_reader;
  localparam int AW     = 18;
  localparam int BW     = 25;
  localparam int TAPS   = 32;
  localparam int ACCW   = 48;
  localparam int ACCW_N = 46;
  localparam int DEPTH  = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_mac_reader_if #(.AWIDTH(AW), .BWIDTH(BW), .ACCW(ACCW))   mif ();
  fifo_mac_reader_if #(.AWIDTH(AW), .BWIDTH(BW), .ACCW(ACCW_N)) nif ();

  fifo_mac_reader #(.AWIDTH(AW), .BWIDTH(BW), .TAPS(TAPS), .ACCW(ACCW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.master)
  );

  // Narrow-accumulator twin fed identically; it must wrap modulo 2^46.
  fifo_mac_reader #(.AWIDTH(AW), .BWIDTH(BW), .TAPS(TAPS), .ACCW(ACCW_N)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (nif.master)
  );

  assign nif.empty   = mif.empty;
  assign nif.a_in    = mif.a_in;
  assign nif.b_in    = mif.b_in;
  assign nif.y_ready = mif.y_ready;

  // ---------------- FIFO model ----------------
  logic [AW-1:0] fq_a[$];
  logic [BW-1:0] fq_b[$];
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_a;
  logic [BW-1:0] wr_b;
  logic          full = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      fq_a.delete();
      fq_b.delete();
    end else begin
      if (mif.rd_en && fq_a.size() > 0) begin
        mif.a_in <= fq_a.pop_front();
        mif.b_in <= fq_b.pop_front();
      end
      if (wr_en) begin
        fq_a.push_back(wr_a);
        fq_b.push_back(wr_b);
      end
    end
    mif.empty <= (fq_a.size() == 0);
    full      <= (fq_a.size() >= DEPTH);
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [ACCW-1:0] exp_q[$];
  longint ref_sum = 0;
  int     ref_n   = 0;

  function automatic void chk(input bit ok, input string name,
                              input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  // Reference: every TAPS consecutive pairs written form one dot-product.
  function automatic void model_push(input logic signed [AW-1:0] a,
                                     input logic signed [BW-1:0] b);
    ref_sum += longint'(a) * longint'(b);
    ref_n++;
    if (ref_n == TAPS) begin
      exp_q.push_back(ref_sum[ACCW-1:0]);
      ref_sum = 0;
      ref_n   = 0;
    end
  endfunction

  function automatic void model_reset();
    ref_sum = 0;
    ref_n   = 0;
    exp_q.delete();
  endfunction

  // ---------------- monitor ----------------
  int pop_idx = 0;
  int lat_q[$];
  int res_t[$];
  int hs_cnt = 0;
  bit prev_valid = 1'b0;
  bit prev_hs = 1'b0;
  bit rand_ready = 1'b0;

  always @(negedge clk) begin
    #2;
    if (rst) begin
      pop_idx    = 0;
      lat_q.delete();
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
      hs_cnt     = 0;
    end else begin
      chk(!(mif.rd_en && mif.empty), "rd_en_while_empty", 64'(mif.rd_en), 64'd0);
      if (mif.rd_en) begin
        pop_idx++;
        if (pop_idx == TAPS) begin
          lat_q.push_back(cyc + 3);
          pop_idx = 0;
        end
      end
      if (mif.y_valid && (!prev_valid || prev_hs)) begin
        res_t.push_back(cyc);
        if (lat_q.size() == 0) chk(1'b0, "result_without_last_pop", 64'(cyc), 64'd0);
        else begin
          int lat;
          lat = lat_q.pop_front();
          chk(cyc == lat, "result_latency", 64'(cyc), 64'(lat));
        end
      end
      if (mif.y_valid && mif.y_ready) begin
        if (exp_q.size() == 0) chk(1'b0, "unexpected_result", 64'(mif.y), 64'd0);
        else begin
          logic [ACCW-1:0] e;
          e = exp_q.pop_front();
          hs_cnt++;
          chk(mif.y == e, "y", 64'(mif.y), 64'(e));
          chk(mif.frame_cnt == 16'(hs_cnt), "frame_cnt", 64'(mif.frame_cnt), 64'(16'(hs_cnt)));
          chk(nif.y_valid && nif.y == e[ACCW_N-1:0], "y_acc46", 64'(nif.y), 64'(e[ACCW_N-1:0]));
        end
      end
      prev_valid = mif.y_valid;
      prev_hs    = mif.y_valid && mif.y_ready;
    end
  end

  always @(negedge clk) begin
    if (rand_ready) mif.y_ready = ($urandom_range(1) == 1);
  end

  // ---------------- driver tasks ----------------
  task automatic push_pair(input logic [AW-1:0] a, input logic [BW-1:0] b, input int rate);
    int t;
    t = 0;
    while (full || $urandom_range(99) >= rate) begin
      @(negedge clk);
      t++;
      if (t > 3000) begin
        chk(1'b0, "push_timeout", 64'(t), 64'd0);
        return;
      end
    end
    wr_en = 1'b1;
    wr_a  = a;
    wr_b  = b;
    model_push($signed(a), $signed(b));
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic push_const(input int n, input logic [AW-1:0] a, input logic [BW-1:0] b);
    for (int i = 0; i < n; i++) push_pair(a, b, 100);
  endtask

  task automatic wait_drain(input int budget);
    int t;
    t = 0;
    while (exp_q.size() != 0 || !mif.empty) begin
      @(negedge clk);
      t++;
      if (t > budget) begin
        chk(1'b0, "drain_timeout", 64'(exp_q.size()), 64'd0);
        break;
      end
    end
    repeat (6) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  logic signed [AW-1:0] a_min = -18'sd131072;
  logic signed [BW-1:0] b_min = -25'sd16777216;
  bit wr_done;

  initial begin
    int t;
    mif.y_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk(mif.y == '0,         "reset_y",         64'(mif.y),         64'd0);
    chk(mif.y_valid == 1'b0, "reset_y_valid",   64'(mif.y_valid),   64'd0);
    chk(mif.frame_cnt == '0, "reset_frame_cnt", 64'(mif.frame_cnt), 64'd0);
    chk(mif.rd_en == 1'b0,   "reset_rd_en",     64'(mif.rd_en),     64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Unit operands: y = 32.
    push_const(TAPS, 18'd1, 25'd1);
    wait_drain(500);

    // Two back-to-back frames of (-1 x 3): -96 each, exactly TAPS cycles apart.
    res_t.delete();
    push_const(2 * TAPS, -18'sd1, 25'sd3);
    wait_drain(500);
    if (res_t.size() == 2) chk(res_t[1] - res_t[0] == TAPS, "frame_spacing",
                               64'(res_t[1] - res_t[0]), 64'(TAPS));
    else chk(1'b0, "frame_result_count", 64'(res_t.size()), 64'd2);

    // Most negative operands: 2^46, which wraps to 0 in the 46-bit twin.
    push_const(TAPS, a_min, b_min);
    wait_drain(500);

    // Backpressure with the FIFO filling up behind a held result.
    mif.y_ready = 1'b0;
    wr_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 70; i++) push_pair(AW'($urandom), BW'($urandom), 100);
        wr_done = 1'b1;
      end
    join_none
    t = 0;
    while (!mif.y_valid && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk(mif.y_valid == 1'b1, "bp_first_valid", 64'(mif.y_valid), 64'd1);
    t = 0;
    while ((t < 20 || !full) && t < 200) begin
      @(negedge clk);
      #1;
      t++;
      chk(mif.rd_en == 1'b0, "bp_rd_en", 64'(mif.rd_en), 64'd0);
      if (exp_q.size() > 0) chk(mif.y == exp_q[0], "bp_y_stable", 64'(mif.y), 64'(exp_q[0]));
    end
    chk(full == 1'b1, "bp_fifo_full", 64'(full), 64'd1);
    @(negedge clk);
    mif.y_ready = 1'b1;
    t = 0;
    while (!wr_done && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk(wr_done == 1'b1, "bp_writer_done", 64'(wr_done), 64'd1);
    wait_drain(500);

    // Random operands, random write gaps, random y_ready; finish the open frame.
    rand_ready = 1'b1;
    for (int i = 0; i < 500; i++) push_pair(AW'($urandom), BW'($urandom), 60);
    while (ref_n != 0) push_pair(AW'($urandom), BW'($urandom), 60);
    wait_drain(3000);
    rand_ready = 1'b0;
    @(negedge clk);
    mif.y_ready = 1'b1;
    repeat (2) @(negedge clk);

    // Reset after 10 pops of a frame: the partial sum must vanish.
    push_const(10, 18'd7, 25'd9);
    wait_drain(200);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk(mif.y == '0,         "rst_mid_y",         64'(mif.y),         64'd0);
    chk(mif.y_valid == 1'b0, "rst_mid_y_valid",   64'(mif.y_valid),   64'd0);
    chk(mif.frame_cnt == '0, "rst_mid_frame_cnt", 64'(mif.frame_cnt), 64'd0);
    chk(mif.rd_en == 1'b0,   "rst_mid_rd_en",     64'(mif.rd_en),     64'd0);
    @(negedge clk);
    push_const(TAPS, 18'd2, 25'd5);
    wait_drain(500);

    chk(exp_q.size() == 0, "scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk(lat_q.size() == 0, "latency_queue_empty", 64'(lat_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
